// File: rtl/an_n13_syndrome_corrector.sv
// an_n13_syndrome_corrector
//   Back end of the A=13 AN-code Barrett decoder. Takes a received 6-bit
//   codeword with its quotient q and residue r (the syndrome), corrects a
//   single arithmetic error of +/-2^i (i=0..5), and emits the 3-bit datum
//   with error flags. Two-stage pipeline with valid/ready flow control, plus
//   saturating link-quality counters.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake (codeword, q, r)
//   out_valid/out_ready        output handshake
//   data_out, raw_cw           decoded datum, originating codeword
//   corrected, uncorrectable   result flags (mutually exclusive)
//   err_pos, err_sign          corrected bit index (7 = none), 1 = +2^i
//   cnt_clr                    synchronous clear of both counters
//   cnt_corr, cnt_unc          saturating event counters
module an_n13_syndrome_corrector #(
  parameter int CNT_W = 16,
  parameter int D_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       codeword,
  input  logic [2:0]       q,
  input  logic [3:0]       r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       data_out,
  output logic [5:0]       raw_cw,
  output logic             corrected,
  output logic             uncorrectable,
  output logic [2:0]       err_pos,
  output logic             err_sign,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_unc
);

  localparam logic signed [4:0] L_DMAX = 5'(D_MAX);

  // advance controls
  logic w_adv1, w_adv2;

  // syndrome lookup
  logic              w_lk_zero, w_lk_ill, w_lk_sign;
  logic [2:0]        w_lk_pos;
  logic signed [2:0] w_lk_delta;

  // stage 1
  logic              r_s1_valid, r_s1_zero, r_s1_ill, r_s1_sign;
  logic [5:0]        r_s1_cw;
  logic [2:0]        r_s1_q, r_s1_pos;
  logic signed [2:0] r_s1_delta;

  // stage 2 (drives outputs)
  logic       r_s2_valid, r_s2_corr, r_s2_unc, r_s2_sign;
  logic [2:0] r_s2_data, r_s2_pos;
  logic [5:0] r_s2_cw;

  // stage 2 next-state
  logic signed [4:0] w_d;
  logic              w_corr, w_unc, w_sign;
  logic [2:0]        w_data, w_pos;

  logic [CNT_W-1:0] r_cnt_corr, r_cnt_unc;
  logic             w_hs;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // r -> (position, sign, quotient correction). Residues of +/-2^i mod 13
  // are all distinct, so each nonzero legal r names exactly one error.
  always_comb begin
    w_lk_zero  = 1'b0;
    w_lk_ill   = 1'b0;
    w_lk_pos   = 3'd7;
    w_lk_sign  = 1'b0;
    w_lk_delta = 3'sd0;
    case (r)
      4'd0:  w_lk_zero = 1'b1;
      4'd1:  begin w_lk_pos = 3'd0; w_lk_sign = 1'b1; end
      4'd2:  begin w_lk_pos = 3'd1; w_lk_sign = 1'b1; end
      4'd4:  begin w_lk_pos = 3'd2; w_lk_sign = 1'b1; end
      4'd8:  begin w_lk_pos = 3'd3; w_lk_sign = 1'b1; end
      4'd3:  begin w_lk_pos = 3'd4; w_lk_sign = 1'b1; w_lk_delta = -3'sd1; end
      4'd6:  begin w_lk_pos = 3'd5; w_lk_sign = 1'b1; w_lk_delta = -3'sd2; end
      4'd12: begin w_lk_pos = 3'd0; w_lk_delta = 3'sd1; end
      4'd11: begin w_lk_pos = 3'd1; w_lk_delta = 3'sd1; end
      4'd9:  begin w_lk_pos = 3'd2; w_lk_delta = 3'sd1; end
      4'd5:  begin w_lk_pos = 3'd3; w_lk_delta = 3'sd1; end
      4'd10: begin w_lk_pos = 3'd4; w_lk_delta = 3'sd2; end
      4'd7:  begin w_lk_pos = 3'd5; w_lk_delta = 3'sd3; end
      default: w_lk_ill = 1'b1;  // r >= 13 cannot come from a real divider
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_ill   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_q     <= '0;
      r_s1_pos   <= 3'd7;
      r_s1_delta <= 3'sd0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_zero  <= w_lk_zero;
        r_s1_ill   <= w_lk_ill;
        r_s1_sign  <= w_lk_sign;
        r_s1_cw    <= codeword;
        r_s1_q     <= q;
        r_s1_pos   <= w_lk_pos;
        r_s1_delta <= w_lk_delta;
      end
    end
  end

  // corrected quotient, sign-extended delta; range -2..10 fits signed 5 bits
  assign w_d = $signed({2'b00, r_s1_q}) + $signed({{2{r_s1_delta[2]}}, r_s1_delta});

  always_comb begin
    w_data = r_s1_q;
    w_corr = 1'b0;
    w_unc  = 1'b0;
    w_pos  = 3'd7;
    w_sign = 1'b0;
    if (r_s1_zero) begin
      w_data = r_s1_q;
    end else if (r_s1_ill || w_d[4] || (w_d > L_DMAX)) begin
      w_unc = 1'b1;
    end else begin
      w_data = w_d[2:0];
      w_corr = 1'b1;
      w_pos  = r_s1_pos;
      w_sign = r_s1_sign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_cw    <= '0;
      r_s2_corr  <= 1'b0;
      r_s2_unc   <= 1'b0;
      r_s2_pos   <= 3'd7;
      r_s2_sign  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_data;
        r_s2_cw   <= r_s1_cw;
        r_s2_corr <= w_corr;
        r_s2_unc  <= w_unc;
        r_s2_pos  <= w_pos;
        r_s2_sign <= w_sign;
      end
    end
  end

  assign w_hs = r_s2_valid && out_ready;

  // clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (cnt_clr) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else begin
      if (w_hs && r_s2_corr && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + 1'b1;
      if (w_hs && r_s2_unc  && (r_cnt_unc  != '1)) r_cnt_unc  <= r_cnt_unc  + 1'b1;
    end
  end

  assign out_valid     = r_s2_valid;
  assign data_out      = r_s2_data;
  assign raw_cw        = r_s2_cw;
  assign corrected     = r_s2_corr;
  assign uncorrectable = r_s2_unc;
  assign err_pos       = r_s2_pos;
  assign err_sign      = r_s2_sign;
  assign cnt_corr      = r_cnt_corr;
  assign cnt_unc       = r_cnt_unc;

endmodule

// File: tb/tb_an_n13_syndrome_corrector.sv
module tb_an_n13_syndrome_corrector;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [5:0] raw;
    logic [2:0] data;
    logic       corr;
    logic       unc;
    logic [2:0] pos;
    logic       sign;
  } exp_t;

  typedef struct packed {
    logic [5:0] cw;
    logic [2:0] q;
    logic [3:0] r;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [5:0] codeword = '0;
  logic [2:0] q = '0;
  logic [3:0] r = '0;
  logic in_ready, out_valid, corrected, uncorrectable, err_sign;
  logic [2:0] data_out, err_pos;
  logic [5:0] raw_cw;
  logic [CNT_W-1:0] cnt_corr, cnt_unc;

  an_n13_syndrome_corrector #(.CNT_W(CNT_W), .D_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .q(q), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .raw_cw(raw_cw), .corrected(corrected),
    .uncorrectable(uncorrectable), .err_pos(err_pos), .err_sign(err_sign),
    .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_unc(cnt_unc));

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  exp_t sb[$];
  int   acc = 0, first_block = -1;
  vec_t dv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int raw, input int data, input bit c, input bit u,
                              input int pos, input bit s);
    exp_t e;
    e.raw = 6'(raw); e.data = 3'(data); e.corr = c; e.unc = u; e.pos = 3'(pos); e.sign = s;
    return e;
  endfunction

  // scoreboard monitor: pops on every output handshake, checks hold-stability while stalled
  initial begin
    exp_t held, act, e;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 1'b0;
      else begin
        act = {raw_cw, data_out, corrected, uncorrectable, err_pos, err_sign};
        if (stalled && out_valid) chk("stall_stable", 32'(act), 32'(held));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_result: got %0h want none", act);
          end else begin
            e = sb.pop_front();
            chk("result", 32'(act), 32'(e));
          end
          stalled = 1'b0;
        end else if (out_valid) begin
          held = act; stalled = 1'b1;
        end else stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [5:0] cw, input logic [2:0] qq, input logic [3:0] rr, input exp_t e);
    int n;
    n = 0;
    codeword = cw; q = qq; r = rr; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      if (first_block < 0) first_block = acc;
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      @(posedge clk);
      sb.push_back(e);
      acc++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cw, n;
    dv[0] = '{6'd26, 3'd2, 4'd0,  mk(26, 2, 0, 0, 7, 0)};
    dv[1] = '{6'd31, 3'd2, 4'd5,  mk(31, 3, 1, 0, 3, 0)};
    dv[2] = '{6'd63, 3'd4, 4'd11, mk(63, 4, 0, 1, 7, 0)};
    dv[3] = '{6'd6,  3'd0, 4'd6,  mk(6,  0, 0, 1, 7, 0)};
    dv[4] = '{6'd14, 3'd1, 4'd13, mk(14, 1, 0, 1, 7, 0)};
    dv[5] = '{6'd15, 3'd3, 4'd15, mk(15, 3, 0, 1, 7, 0)};
    dv[6] = '{6'd0,  3'd0, 4'd0,  mk(0,  0, 0, 0, 7, 0)};
    dv[7] = '{6'd53, 3'd4, 4'd1,  mk(53, 4, 1, 0, 0, 1)};
    dv[8] = '{6'd20, 3'd1, 4'd7,  mk(20, 4, 1, 0, 5, 0)};
    dv[9] = '{6'd40, 3'd3, 4'd1,  mk(40, 3, 1, 0, 0, 1)};

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_raw", 32'(raw_cw), 0);
    chk("rst_flags", 32'({corrected, uncorrectable, err_sign}), 0);
    chk("rst_err_pos", 32'(err_pos), 7);
    chk("rst_cnt", 32'({cnt_corr, cnt_unc}), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // directed vectors, continuous flow
    for (int k = 0; k < 10; k++) send(dv[k].cw, dv[k].q, dv[k].r, dv[k].e);
    drain();

    // sweep: inject +/-2^i into each legal codeword, golden divider for q/r
    for (int d0 = 0; d0 <= 4; d0++)
      for (int i = 0; i < 6; i++)
        for (int s = 0; s < 2; s++) begin
          cw = 13 * d0 + (s == 1 ? (1 << i) : -(1 << i));
          if (cw >= 0 && cw <= 63)
            send(6'(cw), 3'(cw / 13), 4'(cw % 13), mk(cw, d0, 1, 0, i, s[0]));
        end
    drain();

    // backpressure: consumer stalled for 5 cycles while 8 codewords stream
    out_ready = 1'b0;
    acc = 0; first_block = -1;
    fork
      for (int k = 0; k < 8; k++) send(dv[k].cw, dv[k].q, dv[k].r, dv[k].e);
      begin repeat (5) @(posedge clk); #1 out_ready = 1'b1; end
    join
    drain();
    chk("accepts_before_block", 32'(first_block), 2);
    chk("accepts_total", 32'(acc), 8);

    // counters saturate at 3 with CNT_W=2
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_after_clr", 32'({cnt_corr, cnt_unc}), 0);
    for (int k = 0; k < 5; k++) send(6'd31, 3'd2, 4'd5, mk(31, 3, 1, 0, 3, 0));
    drain();
    chk("cnt_corr_sat", 32'(cnt_corr), 3);
    chk("cnt_unc_idle", 32'(cnt_unc), 0);
    send(6'd63, 3'd4, 4'd11, mk(63, 4, 0, 1, 7, 0));
    drain();
    chk("cnt_unc_one", 32'(cnt_unc), 1);

    // clear in the same cycle as a corrected handshake
    out_ready = 1'b0;
    send(6'd31, 3'd2, 4'd5, mk(31, 3, 1, 0, 3, 0));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_setup_valid", 32'(out_valid), 1);
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    chk("cnt_clr_wins", 32'(cnt_corr), 0);
    chk("cnt_clr_unc", 32'(cnt_unc), 0);
    drain();

    // async reset with 2 results in flight
    out_ready = 1'b0;
    send(6'd26, 3'd2, 4'd0, mk(26, 2, 0, 0, 7, 0));
    send(6'd53, 3'd4, 4'd1, mk(53, 4, 1, 0, 0, 1));
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'({raw_cw, data_out}), 0);
    chk("mid_rst_flags", 32'({corrected, uncorrectable, err_sign}), 0);
    chk("mid_rst_pos", 32'(err_pos), 7);
    sb.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_after_rst", 32'(out_valid), 0);
    end
    chk("in_ready_post_rst", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
